// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent programmable dividers of CLK_50_MHz. Each channel has a
// near-50% divided clock and a last-cycle tick. The divisor is swapped only at period boundaries.
module multi_channel_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 19,
    parameter int DEFAULT_DIV = 500000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK_50_MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              div_valid,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_in,
    output logic              div_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(2);
    localparam logic [CH_W:0]    NUM_CH_W = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  p_q    [NUM_CH];
    logic [CNT_W-1:0]  p_d    [NUM_CH];
    logic [CNT_W-1:0]  pdiv_q [NUM_CH];
    logic [CNT_W-1:0]  pdiv_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_inc_s [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wrap_s, apply_s;
    logic              ch_ok_s, accept_s;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        if (v < MIN_P) begin
            return MIN_P;
        end else begin
            return v;
        end
    endfunction

    // Write handshake: out-of-range channels are always ready and the write is dropped
    always_comb begin
        ch_ok_s = ({1'b0, div_ch} < NUM_CH_W);
        if (ch_ok_s) begin
            div_ready = ~pend_q[div_ch];
        end else begin
            div_ready = 1'b1;
        end
        accept_s = div_valid & div_ready & ch_ok_s;
    end

    // Per-channel next state; a pending divisor lands on any edge that starts a new period
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_inc_s[i] = cnt_q[i] + ONE;
            wrap_s[i]    = (cnt_q[i] == (p_q[i] - ONE));
            apply_s[i]   = pend_q[i] & (~en[i] | ~run_q[i] | sync_restart | wrap_s[i]);
            cnt_d[i]     = cnt_q[i];
            run_d[i]     = run_q[i];
            clk_d[i]     = clk_q[i];
            tick_d[i]    = tick_q[i];
            p_d[i]       = p_q[i];
            pdiv_d[i]    = pdiv_q[i];
            pend_d[i]    = pend_q[i];

            if (apply_s[i]) begin
                p_d[i]    = pdiv_q[i];
                pend_d[i] = 1'b0;
            end else begin
                p_d[i]    = p_q[i];
            end

            // Accept never coincides with apply: it needs pend_q low for this channel
            if (accept_s && (div_ch == CH_W'(i))) begin
                pdiv_d[i] = clamp_div(div_in);
                pend_d[i] = 1'b1;
            end else begin
                pdiv_d[i] = pdiv_q[i];
            end

            if (!en[i]) begin
                run_d[i]  = 1'b0;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                tick_d[i] = 1'b0;
            end else if (!run_q[i] || sync_restart) begin
                run_d[i]  = 1'b1;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b1;
                tick_d[i] = 1'b0;
            end else if (wrap_s[i]) begin
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b1;
                tick_d[i] = 1'b0;
            end else begin
                cnt_d[i]  = cnt_inc_s[i];
                clk_d[i]  = (cnt_inc_s[i] < (p_q[i] >> 1));
                tick_d[i] = (cnt_inc_s[i] == (p_q[i] - ONE));
            end
        end
    end

    // Channel state registers
    always_ff @(posedge CLK_50_MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                p_q[i]    <= DEF_P;
                pdiv_q[i] <= DEF_P;
            end
            run_q  <= '0;
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                p_q[i]    <= p_d[i];
                pdiv_q[i] <= pdiv_d[i];
            end
            run_q  <= run_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: per-cycle scoreboard against a bench model,
// a hand-derived vector table, and hand-written corner-case sequences.
module tb_multi_channel_clock_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 19;
    localparam int DEF    = 12;

    typedef struct packed {
        logic [3:0] clk;
        logic [3:0] tick;
    } exp_t;

    typedef struct {
        logic [3:0]  en;
        logic        valid;
        logic [1:0]  ch;
        logic [18:0] din;
        logic        rdy;
        logic [3:0]  clk;
        logic [3:0]  tick;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        sync;
    logic        valid;
    logic [1:0]  ch;
    logic [18:0] din;
    logic        rdy;
    logic [3:0]  clk_o;
    logic [3:0]  tick_o;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];
    vec_t tbl[21];

    int m_cnt[4];
    int m_p[4];
    int m_pdiv[4];
    bit m_run[4];
    bit m_pend[4];
    bit m_clk[4];
    bit m_tick[4];

    logic       r;
    logic [3:0] ck;
    logic [3:0] tk;

    always #5 clk = ~clk;

    multi_channel_clock_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)
    ) dut (
        .CLK_50_MHz(clk), .reset(rst), .en(en), .sync_restart(sync),
        .div_valid(valid), .div_ch(ch), .div_in(din), .div_ready(rdy),
        .clk_out(clk_o), .tick(tick_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_p[i] = DEF; m_pdiv[i] = DEF;
            m_run[i] = 1'b0; m_pend[i] = 1'b0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_apply(input int i);
        if (m_pend[i]) begin
            m_p[i] = m_pdiv[i];
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [3:0] e, input logic s, input logic v,
                              input logic [1:0] c, input logic [18:0] d);
        bit acc;
        acc = v && !m_pend[int'(c)];
        for (int i = 0; i < 4; i++) begin
            if (!e[i]) begin
                model_apply(i);
                m_run[i] = 1'b0; m_cnt[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (!m_run[i] || s) begin
                model_apply(i);
                m_run[i] = 1'b1; m_cnt[i] = 0; m_clk[i] = 1'b1; m_tick[i] = 1'b0;
            end else if (m_cnt[i] == m_p[i] - 1) begin
                model_apply(i);
                m_cnt[i] = 0; m_clk[i] = 1'b1; m_tick[i] = 1'b0;
            end else begin
                m_cnt[i]  = m_cnt[i] + 1;
                m_clk[i]  = (m_cnt[i] < m_p[i] / 2);
                m_tick[i] = (m_cnt[i] == m_p[i] - 1);
            end
            if (acc && int'(c) == i) begin
                m_pdiv[i] = (int'(d) < 2) ? 2 : int'(d);
                m_pend[i] = 1'b1;
            end
        end
    endtask

    // One clock step: drive at negedge, check ready, predict, compare after the edge
    task automatic step(input logic [3:0] e, input logic s, input logic v, input logic [1:0] c,
                        input logic [18:0] d, output logic r_o, output logic [3:0] ck_o,
                        output logic [3:0] tk_o);
        exp_t ex;
        en = e; sync = s; valid = v; ch = c; din = d;
        #1;
        r_o = rdy;
        check("div_ready", 32'(rdy), 32'(!m_pend[int'(c)]));
        model_edge(e, s, v, c, d);
        for (int i = 0; i < 4; i++) begin
            ex.clk[i]  = m_clk[i];
            ex.tick[i] = m_tick[i];
        end
        sb_q.push_back(ex);
        @(posedge clk);
        @(negedge clk);
        ex = sb_q.pop_front();
        ck_o = clk_o;
        tk_o = tick_o;
        check("clk_out", 32'(clk_o), 32'(ex.clk));
        check("tick", 32'(tick_o), 32'(ex.tick));
    endtask

    function automatic vec_t mk(input logic [3:0] e, input logic v, input logic [1:0] c,
                                input logic [18:0] d, input logic rd, input logic [3:0] ce,
                                input logic [3:0] te);
        vec_t t;
        t.en = e; t.valid = v; t.ch = c; t.din = d; t.rdy = rd; t.clk = ce; t.tick = te;
        return t;
    endfunction

    initial begin
        int hi, tks, lows, co;
        logic [8:0] seq_clk, seq_tk;
        logic [3:0] prev;
        bit found;

        // ch1 programmed to P=5, then run two periods
        tbl[0]  = mk(4'b0000, 1'b1, 2'd1, 19'd5, 1'b1, 4'b0000, 4'b0000);
        tbl[1]  = mk(4'b0000, 1'b0, 2'd1, 19'd0, 1'b0, 4'b0000, 4'b0000);
        tbl[2]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0010, 4'b0000);
        tbl[3]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0010, 4'b0000);
        tbl[4]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0000);
        tbl[5]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0000);
        tbl[6]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0010);
        tbl[7]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0010, 4'b0000);
        tbl[8]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0010, 4'b0000);
        tbl[9]  = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0000);
        tbl[10] = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0000);
        tbl[11] = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0010);
        tbl[12] = mk(4'b0010, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0010, 4'b0000);
        tbl[13] = mk(4'b0000, 1'b0, 2'd1, 19'd0, 1'b1, 4'b0000, 4'b0000);
        // ch3 written with 0 behaves as P=2
        tbl[14] = mk(4'b0000, 1'b1, 2'd3, 19'd0, 1'b1, 4'b0000, 4'b0000);
        tbl[15] = mk(4'b0000, 1'b0, 2'd3, 19'd0, 1'b0, 4'b0000, 4'b0000);
        tbl[16] = mk(4'b1000, 1'b0, 2'd3, 19'd0, 1'b1, 4'b1000, 4'b0000);
        tbl[17] = mk(4'b1000, 1'b0, 2'd3, 19'd0, 1'b1, 4'b0000, 4'b1000);
        tbl[18] = mk(4'b1000, 1'b0, 2'd3, 19'd0, 1'b1, 4'b1000, 4'b0000);
        tbl[19] = mk(4'b1000, 1'b0, 2'd3, 19'd0, 1'b1, 4'b0000, 4'b1000);
        tbl[20] = mk(4'b0000, 1'b0, 2'd3, 19'd0, 1'b1, 4'b0000, 4'b0000);

        rst = 1'b1; en = '0; sync = 1'b0; valid = 1'b0; ch = '0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_clk_out", 32'(clk_o), 32'h0);
        check("reset_tick", 32'(tick_o), 32'h0);
        check("reset_ready", 32'(rdy), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 21; k++) begin
            step(tbl[k].en, 1'b0, tbl[k].valid, tbl[k].ch, tbl[k].din, r, ck, tk);
            check("tbl_ready", 32'(r), 32'(tbl[k].rdy));
            check("tbl_clk", 32'(ck), 32'(tbl[k].clk));
            check("tbl_tick", 32'(tk), 32'(tbl[k].tick));
        end

        // ch0 at the default divisor: two full periods
        hi = 0; tks = 0;
        for (int j = 0; j < 2 * DEF; j++) begin
            step(4'b0001, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
            hi += int'(ck[0]);
            tks += int'(tk[0]);
        end
        check("default_high_cycles", 32'(hi), 32'(DEF));
        check("default_ticks", 32'(tks), 32'd2);
        step(4'b0000, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);

        // ch2 P=8 retuned to 4 mid-period at cnt=3
        step(4'b0000, 1'b0, 1'b1, 2'd2, 19'd8, r, ck, tk);
        step(4'b0000, 1'b0, 1'b0, 2'd2, 19'd0, r, ck, tk);
        repeat (4) step(4'b0100, 1'b0, 1'b0, 2'd2, 19'd0, r, ck, tk);
        lows = 0; seq_clk = '0; seq_tk = '0;
        for (int j = 0; j < 9; j++) begin
            step(4'b0100, 1'b0, (j == 0), 2'd2, 19'd4, r, ck, tk);
            if (j == 0) check("retune_ready_at_write", 32'(r), 32'h1);
            else if (!r) lows++;
            seq_clk[j] = ck[2];
            seq_tk[j]  = tk[2];
        end
        check("retune_ready_low_cycles", 32'(lows), 32'd4);
        check("retune_clk_seq", 32'(seq_clk), 32'h130);
        check("retune_tick_seq", 32'(seq_tk), 32'h088);
        step(4'b0000, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);

        // ch0 P=4 and ch1 P=6 out of phase, then a global restart
        step(4'b0000, 1'b0, 1'b1, 2'd0, 19'd4, r, ck, tk);
        step(4'b0000, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
        step(4'b0000, 1'b0, 1'b1, 2'd1, 19'd6, r, ck, tk);
        step(4'b0000, 1'b0, 1'b0, 2'd1, 19'd0, r, ck, tk);
        step(4'b0001, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
        repeat (3) step(4'b0011, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
        step(4'b0011, 1'b1, 1'b0, 2'd0, 19'd0, r, ck, tk);
        check("restart_both_high", 32'(ck[1:0]), 32'h3);
        prev = ck; co = 0;
        for (int j = 0; j < 24; j++) begin
            step(4'b0011, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
            if (ck[0] && !prev[0] && ck[1] && !prev[1]) co++;
            prev = ck;
        end
        check("restart_coincident_rises", 32'(co), 32'd2);

        // reset mid-period with a pending write on ch0
        found = 1'b0;
        for (int j = 0; j < 8 && !found; j++) begin
            step(4'b0001, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
            if (m_cnt[0] == 0 && m_run[0]) found = 1'b1;
        end
        check("prereset_aligned", 32'(found), 32'h1);
        step(4'b0001, 1'b0, 1'b1, 2'd0, 19'd7, r, ck, tk);
        check("prereset_clk_high", 32'(ck[0]), 32'h1);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_clk_out", 32'(clk_o), 32'h0);
        check("async_reset_tick", 32'(tick_o), 32'h0);
        check("async_reset_ready", 32'(rdy), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int j = 0; j < DEF; j++) begin
            step(4'b0001, 1'b0, 1'b0, 2'd0, 19'd0, r, ck, tk);
            if (j == 0) check("postreset_first_high", 32'(ck[0]), 32'h1);
            hi += int'(ck[0]);
        end
        check("postreset_default_high", 32'(hi), 32'(DEF / 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised, NUM_CH-channel successor to the fixed 50 MHz -> 100 Hz divider.
- Each channel derives a registered, near-50%-duty divided clock and a one-cycle wrap tick from CLK_50_MHz.
- Each channel's divisor is programmable at runtime through a valid/ready write port, with glitch-free update at the period boundary.
- Also provides per-channel enable and a global phase-alignment restart. Feeds synth note/envelope timing and control-rate logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (>=1).
- CNT_W, 19, counter and divisor width in bits.
- DEFAULT_DIV, 500000, reset divisor for every channel, as a full period in CLK_50_MHz cycles (100 Hz). Must be < 2^CNT_W.
- CH_W, max(1, clog2(NUM_CH)), channel-select width (derived).

Ports:
- CLK_50_MHz  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync_restart  in  1  restarts all running channels at phase 0.
- div_valid  in  1  divisor write request.
- div_ch  in  CH_W  target channel of the write.
- div_in  in  CNT_W  requested period P in input cycles.
- div_ready  out  1  write can be accepted (= ~pending[div_ch]).
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle strobe in the last cycle of each period.

Behaviour:
- Reset (async, active-high):
  - cnt = 0, running = 0, pending = 0.
  - Active divisor P = pending divisor = DEFAULT_DIV.
  - clk_out = 0, tick = 0, so div_ready = 1 after reset.
- Per channel, at each rising edge, evaluated in priority order:
  1. en = 0: running <= 0, cnt <= 0, clk_out <= 0, tick <= 0. A pending divisor is applied (P <= pend_div, pending <= 0).
  2. en = 1 and (running = 0 or sync_restart = 1): running <= 1, cnt <= 0, clk_out <= 1, tick <= 0. A pending divisor is applied first.
  3. Running, cnt = P-1 (wrap): cnt <= 0, clk_out <= 1. A pending divisor is applied at this edge. The new P governs the period that starts here.
  4. Running otherwise: cnt <= cnt+1.
     - clk_out <= (cnt+1 < floor(P/2)).
     - tick <= (cnt+1 = P-1).
- Waveform:
  - clk_out is high for floor(P/2) cycles and low for ceil(P/2) cycles; odd P gives a longer low phase.
  - tick is high exactly in the cycle where cnt = P-1, once per period.
  - The first high cycle starts one edge after en is sampled high; there is no partial first period.
- Divisor write handshake:
  - Accepted on an edge where div_valid & div_ready.
  - On accept: pend_div[div_ch] <= clamp(div_in), pending[div_ch] <= 1.
  - div_ready is combinational from pending[div_ch]. It stays low for that channel until the update is applied; other channels are unaffected.
  - div_ch >= NUM_CH: div_ready = 1, the write is accepted and discarded.
- Clamp: div_in < 2 is stored as 2. No other range checks.
- The active P never changes mid-period, so clk_out has no runt pulses.
- sync_restart:
  - Affects only enabled channels.
  - A restart coinciding with a wrap takes the restart path, so tick is suppressed that cycle.
- Width rule: all counter and compare arithmetic is CNT_W-bit unsigned. cnt never exceeds P-1.
- Reset asserted mid-operation clears everything immediately, including any pending update.

Test Plan:
- Reset, en = 4'b0001, no writes -> clk_out[0] high 250000 / low 250000 cycles; tick[0] every 500000 cycles in the last cycle; channels 1-3 stay 0.
- Write ch1 div_in = 5, then en[1] = 1 -> clk_out[1] pattern 1,1,0,0,0 repeating; tick[1] on the 5th cycle; div_ready low only while ch1 is pending.
- Ch2 running with P = 8; write div_in = 4 at cnt = 3 -> P = 8 period completes unchanged, the next period is 1,1,0,0; div_ready (div_ch = 2) drops for 4 cycles then returns to 1.
- Write div_in = 0 to ch3, then enable -> behaves as P = 2: clk_out toggles every cycle and tick is high every low cycle.
- Ch0 P = 4, ch1 P = 6, both running out of phase; pulse sync_restart -> the next cycle both have clk_out = 1 at cnt = 0 and their rising edges coincide every 12 cycles.
- Assert reset mid-period with a write pending -> outputs 0 immediately (asynchronous); after release the channel runs at DEFAULT_DIV, not the pending value.
